// File: rtl/fp_add_aligner_if.sv
// Operand/result handshake bundle for the binary32 add/sub alignment front-end.
// The master side is the producer/consumer; the slave side is the aligner.
interface fp_add_aligner_if;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        operator_in;
    logic        in_valid;
    logic        in_ready;
    logic        sign_out;
    logic [7:0]  exp_out;
    logic [25:0] mantis_out;
    logic        operator_out;
    logic        loss;
    logic        out_valid;
    logic        out_ready;

    modport slave (
        input  a_in, b_in, operator_in, in_valid, out_ready,
        output in_ready, sign_out, exp_out, mantis_out, operator_out, loss, out_valid
    );

    modport master (
        output a_in, b_in, operator_in, in_valid, out_ready,
        input  in_ready, sign_out, exp_out, mantis_out, operator_out, loss, out_valid
    );
endinterface

// File: rtl/fp_add_aligner.sv
// Binary32 add/sub front-end: unpack, order by magnitude, align the smaller
// mantissa one bit per cycle with sticky collection, then add or subtract.
module fp_add_aligner #(
    parameter int MAX_SHIFT = 26
) (
    input  logic              clk,
    input  logic              rst_n,
    fp_add_aligner_if.slave   bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ALIGN = 2'd1;
    localparam logic [1:0] ADD   = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]  state;
    logic [4:0]  cnt;
    logic        sticky;
    logic [25:0] m_l;
    logic [25:0] m_s;
    logic [7:0]  exp_l;
    logic        sign_l;
    logic        eff_sub;

    logic        sa, sb;
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic [25:0] ma, mb;
    logic        a_big;
    logic [7:0]  diff;
    logic [4:0]  shift;
    logic [25:0] sum;

    function automatic logic [4:0] sat_shift(input logic [7:0] d);
        if (d > 8'(MAX_SHIFT))
            return 5'(MAX_SHIFT);
        return d[4:0];
    endfunction

    // Unpack and order: a zero exponent flushes the operand's mantissa to 0.
    always_comb begin
        sa    = bus.a_in[31];
        ea    = bus.a_in[30:23];
        fa    = bus.a_in[22:0];
        sb    = bus.b_in[31];
        eb    = bus.b_in[30:23];
        fb    = bus.b_in[22:0];
        ma    = (ea != 8'd0) ? {2'b01, fa, 1'b0} : 26'd0;
        mb    = (eb != 8'd0) ? {2'b01, fb, 1'b0} : 26'd0;
        a_big = ({ea, fa} >= {eb, fb});
        diff  = a_big ? (ea - eb) : (eb - ea);
        shift = sat_shift(diff);
        sum   = eff_sub ? (m_l - m_s) : (m_l + m_s);
    end

    assign bus.in_ready  = (state == IDLE) && rst_n;
    assign bus.out_valid = (state == DONE);

    // Datapath registers carry no reset; an aborted operation is never presented.
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.in_valid) begin
            m_l     <= a_big ? ma : mb;
            m_s     <= a_big ? mb : ma;
            exp_l   <= a_big ? ea : eb;
            sign_l  <= a_big ? sa : (sb ^ bus.operator_in);
            eff_sub <= sa ^ sb ^ bus.operator_in;
        end else if (state == ALIGN) begin
            m_s <= m_s >> 1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= IDLE;
            cnt              <= 5'd0;
            sticky           <= 1'b0;
            bus.sign_out     <= 1'b0;
            bus.exp_out      <= 8'd0;
            bus.mantis_out   <= 26'd0;
            bus.operator_out <= 1'b0;
            bus.loss         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        cnt    <= shift;
                        sticky <= 1'b0;
                        state  <= (shift != 5'd0) ? ALIGN : ADD;
                    end
                end
                ALIGN: begin
                    sticky <= sticky | m_s[0];
                    cnt    <= cnt - 5'd1;
                    if (cnt == 5'd1)
                        state <= ADD;
                end
                ADD: begin
                    bus.mantis_out   <= sum;
                    bus.loss         <= sticky;
                    bus.operator_out <= eff_sub;
                    bus.exp_out      <= exp_l;
                    bus.sign_out     <= (sum == 26'd0) ? 1'b0 : sign_l;
                    state            <= DONE;
                end
                default: begin
                    if (bus.out_ready)
                        state <= IDLE;
                end
            endcase
        end
    end

endmodule
